// File: rtl/hour_chime_player.sv
// Hourly chime player: plays N piezo tone bursts per top-of-hour strobe (N = 12-hour hour).
// Latency: accepting edge loads BEEP with piezo=1, busy=1, beeps_left=N on that same edge.
// Backpressure: none; triggers arriving while a sequence plays (or while muted) are dropped.
module hour_chime_player #(
  parameter int TONE_HALF = 1,
  parameter int BEEP_ON   = 200,
  parameter int BEEP_OFF  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chime_trig,
  input  logic       test_trig,
  input  logic [4:0] hour24,
  input  logic       mute,
  output logic       piezo,
  output logic       busy,
  output logic [3:0] beeps_left
);

  // Phase counter must hold the longer of the burst and gap lengths.
  localparam int MAXPH = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int CW    = $clog2(MAXPH + 1);
  localparam int TW    = $clog2(TONE_HALF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_piezo;
  logic            r_busy;
  logic [3:0]      r_beeps_left;
  logic [CW-1:0]   r_ph_cnt;
  logic [TW-1:0]   r_tone_cnt;

  logic            w_chime_ok;
  logic            w_accept;
  logic [3:0]      w_hmod;
  logic [3:0]      w_n;

  // Trigger qualification and burst-count decode (chime_trig takes precedence over test_trig).
  always_comb begin
    w_chime_ok = chime_trig && (hour24 <= 5'd23);
    w_accept   = !mute && (chime_trig ? w_chime_ok : test_trig);
    w_hmod     = (hour24 >= 5'd12) ? 4'(hour24 - 5'd12) : hour24[3:0];
    if (chime_trig) begin
      w_n = (w_hmod == 4'd0) ? 4'd12 : w_hmod;
    end else begin
      w_n = 4'd1;
    end
  end

  // Sequencer: IDLE -> BEEP <-> GAP, counters restart on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_piezo      <= 1'b0;
      r_busy       <= 1'b0;
      r_beeps_left <= 4'd0;
      r_ph_cnt     <= '0;
      r_tone_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= BEEP;
            r_busy       <= 1'b1;
            r_piezo      <= 1'b1;
            r_beeps_left <= w_n;
            r_ph_cnt     <= '0;
            r_tone_cnt   <= '0;
          end
        end
        BEEP: begin
          if (r_ph_cnt == CW'(BEEP_ON - 1)) begin
            r_ph_cnt   <= '0;
            r_tone_cnt <= '0;
            r_piezo    <= 1'b0;
            if (r_beeps_left > 4'd1) begin
              r_state      <= GAP;
              r_beeps_left <= r_beeps_left - 4'd1;
            end else begin
              r_state      <= IDLE;
              r_beeps_left <= 4'd0;
              r_busy       <= 1'b0;
            end
          end else begin
            r_ph_cnt <= r_ph_cnt + CW'(1);
            if (r_tone_cnt == TW'(TONE_HALF - 1)) begin
              r_tone_cnt <= '0;
              r_piezo    <= ~r_piezo;
            end else begin
              r_tone_cnt <= r_tone_cnt + TW'(1);
            end
          end
        end
        GAP: begin
          if (r_ph_cnt == CW'(BEEP_OFF - 1)) begin
            r_state    <= BEEP;
            r_ph_cnt   <= '0;
            r_tone_cnt <= '0;
            r_piezo    <= 1'b1;
          end else begin
            r_ph_cnt <= r_ph_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_piezo <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign piezo      = r_piezo;
  assign busy       = r_busy;
  assign beeps_left = r_beeps_left;

endmodule

// File: tb/tb_hour_chime_player.sv
// Bench for hour_chime_player: timeline model of the chime sequence checked every cycle,
// plus literal busy-length and reset-state expectations per directed scenario.
// Inputs driven on falling edges, outputs sampled on falling edges.
module tb_hour_chime_player;

  localparam int TH  = 1;
  localparam int ON  = 200;
  localparam int OFF = 300;

  logic       clk;
  logic       rst;
  logic       chime_trig;
  logic       test_trig;
  logic [4:0] hour24;
  logic       mute;
  logic       piezo;
  logic       busy;
  logic [3:0] beeps_left;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  hour_chime_player #(.TONE_HALF(TH), .BEEP_ON(ON), .BEEP_OFF(OFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .chime_trig (chime_trig),
    .test_trig  (test_trig),
    .hour24     (hour24),
    .mute       (mute),
    .piezo      (piezo),
    .busy       (busy),
    .beeps_left (beeps_left)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: a sequence is just (start accepted, burst count n, cycles elapsed k).
  bit m_active = 0;
  int m_k      = 0;
  int m_n      = 0;

  always @(posedge clk) begin
    bit was_active;
    was_active = m_active;
    if (rst) begin
      m_active = 0;
    end else if (was_active) begin
      m_k = m_k + 1;
      if (m_k >= m_n * ON + (m_n - 1) * OFF) m_active = 0;
    end else if (!mute && (chime_trig ? (hour24 <= 23) : test_trig)) begin
      m_active = 1;
      m_k      = 0;
      if (chime_trig) m_n = (hour24 % 12 == 0) ? 12 : (hour24 % 12);
      else            m_n = 1;
    end
  end

  // Every-cycle comparison of all outputs against the timeline model.
  always @(negedge clk) begin
    if (chk_en) begin
      int  per, idx, w, e_bl;
      bit  e_p, e_b;
      per = ON + OFF;
      if (m_active) begin
        idx  = m_k / per;
        w    = m_k % per;
        e_b  = 1;
        e_bl = m_n - idx - ((w >= ON) ? 1 : 0);
        e_p  = (w < ON) && (((w / TH) % 2) == 0);
      end else begin
        e_b  = 0;
        e_bl = 0;
        e_p  = 0;
      end
      n_checks++;
      if (piezo !== e_p || busy !== e_b || beeps_left !== 4'(e_bl)) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model_cmp t=%0t got p=%b b=%b bl=%0d expected p=%b b=%b bl=%0d",
                   $time, piezo, busy, beeps_left, e_p, e_b, e_bl);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fire(input bit c, input bit t, input logic [4:0] h);
    @(negedge clk);
    chime_trig = c;
    test_trig  = t;
    hour24     = h;
    @(negedge clk);
    chime_trig = 0;
    test_trig  = 0;
  endtask

  // Counts busy cycles from the current falling edge until busy drops (bounded).
  task automatic wait_idle(output int len);
    len = 0;
    while (busy === 1'b1 && len < 7000) begin
      len++;
      @(negedge clk);
    end
    if (len >= 7000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy still high expected idle");
    end
  endtask

  initial begin
    int len;
    rst = 1; chime_trig = 0; test_trig = 0; hour24 = 0; mute = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_piezo", int'(piezo), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_bl", int'(beeps_left), 0);
    chk_en = 1;

    // 1: hour 14 -> 2 bursts, 700 busy cycles
    fire(1, 0, 5'd14);
    check("h14_first_bl", int'(beeps_left), 2);
    check("h14_first_piezo", int'(piezo), 1);
    wait_idle(len);
    check("h14_busy_len", len, 700);

    // 2: hours 0, 12 -> 12 bursts; 13 -> 1; 25 -> ignored
    fire(1, 0, 5'd0);
    check("h0_first_bl", int'(beeps_left), 12);
    wait_idle(len);
    check("h0_busy_len", len, 5700);
    fire(1, 0, 5'd12);
    wait_idle(len);
    check("h12_busy_len", len, 5700);
    fire(1, 0, 5'd13);
    wait_idle(len);
    check("h13_busy_len", len, 200);
    fire(1, 0, 5'd25);
    wait_idle(len);
    check("h25_busy_len", len, 0);

    // 3: muted trigger ignored; mute mid-sequence has no effect
    mute = 1;
    fire(1, 0, 5'd9);
    wait_idle(len);
    check("mute_busy_len", len, 0);
    mute = 0;
    fire(1, 0, 5'd3);
    repeat (50) @(negedge clk);
    mute = 1;
    wait_idle(len);
    check("mute_mid_rest_len", len, 1150);
    mute = 0;

    // 4: trigger inside a gap is dropped; simultaneous triggers -> chime wins
    fire(1, 0, 5'd5);
    repeat (249) @(negedge clk);
    chime_trig = 1; hour24 = 5'd9;
    @(negedge clk);
    chime_trig = 0;
    wait_idle(len);
    check("h5_gap_trig_rest_len", len, 1950);
    fire(1, 1, 5'd3);
    check("both_first_bl", int'(beeps_left), 3);
    wait_idle(len);
    check("both_busy_len", len, 1200);

    // 5: test burst ignores hour24
    fire(0, 1, 5'd7);
    check("test_first_bl", int'(beeps_left), 1);
    wait_idle(len);
    check("test_busy_len", len, 200);

    // 6: reset mid-sequence, then a normal 1-burst chime
    fire(1, 0, 5'd11);
    repeat (349) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_piezo", int'(piezo), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_bl", int'(beeps_left), 0);
    fire(1, 0, 5'd1);
    wait_idle(len);
    check("h1_busy_len", len, 200);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
